// File: rtl/merge2_leaf_arbiter_pkg.sv
// Shared types and constants for the two-input leaf merge arbiter.
// Holds the lock FSM encoding, the default flit width and the tail-bit position.
package merge2_leaf_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam int FLIT_W = 9;

  // The tail marker is always the top bit of a flit.
  function automatic int tail_idx(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/merge2_leaf_arbiter_if.sv
// Flit bus between two requesters, the merge arbiter and the downstream leaf.
// slave = arbiter side, master = requesters plus downstream side.
interface merge2_leaf_arbiter_if
  import merge2_leaf_arbiter_pkg::*;
#(
  parameter int W = FLIT_W
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_src;
  logic         busy;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_valid, out_src, busy
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_valid, out_src, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
// The pointer moves to the other port only when the caller signals an update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic       o_gnt_vld,
  output logic       o_gnt_idx
);
  logic r_ptr;

  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_idx = (i_req == 2'b11) ? r_ptr : i_req[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= 1'b0;
    else if (i_upd) r_ptr <= ~o_gnt_idx;
  end
endmodule

// File: rtl/merge2_leaf_arbiter.sv
// Merges two packetised flit streams into one registered output without interleaving packets.
// Optional macro MERGE2_PERF_CNT_EN adds saturating per-port tail-flit counters.
module merge2_leaf_arbiter
  import merge2_leaf_arbiter_pkg::*;
#(
  parameter int W = FLIT_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  merge2_leaf_arbiter_if.slave  bus
`ifdef MERGE2_PERF_CNT_EN
  ,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
`endif
);
  localparam int TAIL = tail_idx(W);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_slot_free;
  logic           w_arb_vld;
  logic           w_arb_idx;
  logic           w_gnt_vld;
  logic           w_sel;
  logic           w_sel_valid;
  logic [W-1:0]   w_sel_data;
  logic           w_tail;
  logic           w_accept;
  logic           w_hdr;
  logic           w_rdy0;
  logic           w_rdy1;
  logic [W-1:0]   r_data_p1;
  logic           r_src_p1;
  logic           r_vld_p1;

  assign w_slot_free = !r_vld_p1 | bus.out_ready;

  rr_arb2 u_rr_arb2 (
    .clk       (CLK),
    .rst       (RESET),
    .i_req     ({bus.in1_valid, bus.in0_valid}),
    .i_upd     (w_hdr),
    .o_gnt_vld (w_arb_vld),
    .o_gnt_idx (w_arb_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_vld   = w_arb_vld;
    w_sel       = w_arb_idx;
    case (r_state)
      ST_LOCK0: begin w_gnt_vld = 1'b1; w_sel = 1'b0; end
      ST_LOCK1: begin w_gnt_vld = 1'b1; w_sel = 1'b1; end
      default:  ;
    endcase
    w_sel_valid = w_sel ? bus.in1_valid : bus.in0_valid;
    w_sel_data  = w_sel ? bus.in1_data  : bus.in0_data;
    w_tail      = w_sel_data[TAIL];
    w_rdy0      = w_gnt_vld & !w_sel & w_slot_free;
    w_rdy1      = w_gnt_vld &  w_sel & w_slot_free;
    w_accept    = w_gnt_vld & w_sel_valid & w_slot_free;
    // A header is the first flit taken while unlocked; only it moves the rr pointer.
    w_hdr       = w_accept & (r_state == ST_IDLE);
    if (w_accept) begin
      if (r_state == ST_IDLE && !w_tail) w_state_nxt = w_sel ? ST_LOCK1 : ST_LOCK0;
      else if (r_state != ST_IDLE && w_tail) w_state_nxt = ST_IDLE;
    end
  end

  // Readies are forced low while reset is held, independent of the arbitration path.
  assign bus.in0_ready = w_rdy0 & !RESET;
  assign bus.in1_ready = w_rdy1 & !RESET;

  // Stage p1: single output register, reloaded on accept, emptied on drain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_src_p1  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_sel_data;
        r_src_p1  <= w_sel;
      end else if (bus.out_ready) begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_data_p1;
  assign bus.out_valid = r_vld_p1;
  assign bus.out_src   = r_src_p1;
  assign bus.busy      = (r_state != ST_IDLE);

`ifdef MERGE2_PERF_CNT_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_accept && w_tail) begin
      if (w_sel) r_cnt1 <= sat_inc(r_cnt1);
      else       r_cnt0 <= sat_inc(r_cnt0);
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_merge2_leaf_arbiter.sv
// Bench for merge2_leaf_arbiter: packet-level reference model, per-port flit scoreboard,
// directed scenarios and a randomized run with occasional resets.
module tb_merge2_leaf_arbiter;
  import merge2_leaf_arbiter_pkg::*;
  localparam int W = 9;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  merge2_leaf_arbiter_if #(.W(W)) bus ();
`ifdef MERGE2_PERF_CNT_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

  merge2_leaf_arbiter #(.W(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus      (bus)
`ifdef MERGE2_PERF_CNT_EN
    ,
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: owner of the current packet (-1 none), rr pointer, output slot.
  int           m_owner;
  bit           m_rr;
  bit           m_vld;
  logic [W-1:0] m_data;
  bit           m_src;
  int           m_cnt0, m_cnt1;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           sb_last_tail;
  bit           sb_last_src;
  bit           src_log[$];
  bit           acc0, acc1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 1'b0; m_vld = 1'b0; m_data = '0; m_src = 1'b0;
    m_cnt0 = 0; m_cnt1 = 0;
    q0.delete(); q1.delete();
    sb_last_tail = 1'b1; sb_last_src = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit sf, gv, g, er0, er1;
    logic [W-1:0] d, f;
    @(negedge CLK);
    sf = !m_vld || bus.out_ready;
    gv = 1'b0; g = 1'b0;
    if (m_owner >= 0) begin gv = 1'b1; g = m_owner[0]; end
    else if (bus.in0_valid && bus.in1_valid) begin gv = 1'b1; g = m_rr; end
    else if (bus.in0_valid) gv = 1'b1;
    else if (bus.in1_valid) begin gv = 1'b1; g = 1'b1; end
    er0 = !RESET && gv && !g && sf;
    er1 = !RESET && gv &&  g && sf;
    chk("out_valid", bus.out_valid, m_vld);
    chk("out_data",  bus.out_data,  m_data);
    chk("out_src",   bus.out_src,   m_src);
    chk("busy",      bus.busy,      m_owner >= 0);
    chk("in0_ready", bus.in0_ready, er0);
    chk("in1_ready", bus.in1_ready, er1);
`ifdef MERGE2_PERF_CNT_EN
    chk("pkt_cnt0", pkt_cnt0, m_cnt0);
    chk("pkt_cnt1", pkt_cnt1, m_cnt1);
`endif
    if (!RESET && bus.out_valid && bus.out_ready) begin
      src_log.push_back(bus.out_src);
      if (!sb_last_tail) chk("no_interleave", bus.out_src, sb_last_src);
      if ((bus.out_src ? q1.size() : q0.size()) == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        f = bus.out_src ? q1.pop_front() : q0.pop_front();
        chk("sb_order", bus.out_data, f);
      end
      sb_last_src  = bus.out_src;
      sb_last_tail = bus.out_data[W-1];
    end
    @(posedge CLK);
    acc0 = 1'b0; acc1 = 1'b0;
    if (!RESET) begin
      acc0 = er0 && bus.in0_valid;
      acc1 = er1 && bus.in1_valid;
      if (acc0 || acc1) begin
        d = acc1 ? bus.in1_data : bus.in0_data;
        if (acc1) q1.push_back(d); else q0.push_back(d);
        if (m_owner < 0) begin
          m_rr = !g;
          if (!d[W-1]) m_owner = int'(g);
        end else if (d[W-1]) m_owner = -1;
        if (d[W-1]) begin
          if (g) m_cnt1 = (m_cnt1 == 65535) ? m_cnt1 : m_cnt1 + 1;
          else   m_cnt0 = (m_cnt0 == 65535) ? m_cnt0 : m_cnt0 + 1;
        end
        m_vld = 1'b1; m_data = d; m_src = g;
      end else if (bus.out_ready) begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    model_reset();
    repeat (n) cycle();
    RESET = 1'b0;
  endtask

  int          gen_len[2], gen_idx[2];
  logic [7:0]  gen_pay[2];
  int          i0, i1;
  logic [W-1:0] held;

  initial begin
    bus.in0_data = '0; bus.in0_valid = 1'b1;
    bus.in1_data = '0; bus.in1_valid = 1'b1;
    bus.out_ready = 1'b1;
    RESET = 1'b1;
    model_reset();
    // Reset state with both requesters asserting valid.
    #1;
    chk("rst_in0_ready", bus.in0_ready, 0);
    chk("rst_in1_ready", bus.in1_ready, 0);
    do_reset(2);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);

    // Single-flit packet from port 0.
    bus.in1_valid = 1'b0; bus.in0_data = 9'h1AA; bus.in0_valid = 1'b1;
    #1;
    chk("p1_in0_ready", bus.in0_ready, 1);
    cycle();
    bus.in0_valid = 1'b0;
    chk("p1_out_data", bus.out_data, 9'h1AA);
    chk("p1_out_src", bus.out_src, 0);
    chk("p1_out_valid", bus.out_valid, 1);
    chk("p1_busy", bus.busy, 0);
    cycle();

    // Two contending 3-flit packets from rr=0.
    do_reset(1);
    src_log.delete();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in0_valid = (i0 < 3); bus.in0_data = {i0 == 2, 8'h10 + 8'(i0)};
      bus.in1_valid = (i1 < 3); bus.in1_data = {i1 == 2, 8'h20 + 8'(i1)};
      cycle();
      if (c == 0) chk("p3_busy_first", bus.busy, 1);
      if (acc0) i0++;
      if (acc1) i1++;
    end
    chk("p3_count", src_log.size(), 6);
    if (src_log.size() == 6)
      chk("p3_order", {src_log[0], src_log[1], src_log[2], src_log[3], src_log[4], src_log[5]}, 6'b000111);

    // Back-to-back single-flit packets on both ports alternate.
    src_log.delete();
    for (int c = 0; c < 6; c++) begin
      bus.in0_valid = 1'b1; bus.in0_data = {1'b1, 8'hA0 + 8'(c)};
      bus.in1_valid = 1'b1; bus.in1_data = {1'b1, 8'hB0 + 8'(c)};
      cycle();
    end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    cycle();
    if (src_log.size() >= 4)
      chk("p4_alt", {src_log[0], src_log[1], src_log[2], src_log[3]}, 4'b0101);
    else chk("p4_count", src_log.size(), 4);

    // Downstream stall holds the output and blocks both inputs.
    bus.in0_valid = 1'b1; bus.in0_data = {1'b1, 8'h55}; bus.out_ready = 1'b1;
    cycle();
    bus.in0_data = {1'b1, 8'h66}; bus.in1_valid = 1'b1; bus.in1_data = {1'b1, 8'h77};
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("st_hold", bus.out_data, 9'h155);
      chk("st_rdy0", bus.in0_ready, 0);
      chk("st_rdy1", bus.in1_ready, 0);
      cycle();
    end
    bus.out_ready = 1'b1; bus.in1_valid = 1'b0;
    cycle();
    bus.in0_valid = 1'b0;
    chk("st_next", bus.out_data, 9'h166);
    chk("st_next_vld", bus.out_valid, 1);
    cycle();
    cycle();

    // Reset in the middle of a port-1 packet.
    held = {1'b0, 8'hC0};
    bus.in1_valid = 1'b1; i1 = 0;
    for (int c = 0; c < 6 && i1 < 2; c++) begin
      bus.in1_data = {1'b0, 8'hC0 + 8'(i1)};
      cycle();
      if (acc1) i1++;
    end
    chk("rs_busy_before", bus.busy, 1);
    RESET = 1'b1;
    model_reset();
    #1;
    chk("rs_out_valid", bus.out_valid, 0);
    chk("rs_busy", bus.busy, 0);
    cycle();
    RESET = 1'b0;
    bus.in0_valid = 1'b1; bus.in0_data = {1'b1, 8'hD0};
    bus.in1_valid = 1'b1; bus.in1_data = {1'b0, 8'hC2};
    cycle();
    chk("rs_new_src", bus.out_src, 0);
    bus.in0_valid = 1'b0;
    cycle();
    chk("rs_hdr_busy", bus.busy, 1);
    bus.in1_data = {1'b1, 8'hC3};
    cycle();
    bus.in1_valid = 1'b0;
    cycle();
    chk("rs_done_busy", bus.busy, 0);

`ifdef MERGE2_PERF_CNT_EN
    do_reset(1);
    bus.in1_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in1_data = {1'b1, 8'(c)};
      cycle();
    end
    bus.in1_valid = 1'b0;
    cycle();
    chk("pc_cnt1", pkt_cnt1, 5);
    chk("pc_cnt0", pkt_cnt0, 0);
    force dut.r_cnt1 = 16'hFFFF;
    #1;
    release dut.r_cnt1;
    m_cnt1 = 65535;
    bus.in1_valid = 1'b1; bus.in1_data = {1'b1, 8'h99};
    cycle();
    bus.in1_valid = 1'b0;
    cycle();
    chk("pc_sat", pkt_cnt1, 16'hFFFF);
`endif

    // Randomized traffic with random backpressure and rare resets.
    for (int p = 0; p < 2; p++) begin
      gen_len[p] = $urandom_range(1, 4); gen_idx[p] = 0; gen_pay[p] = 8'($urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset(1);
      bus.in0_valid = ($urandom_range(0, 3) != 0);
      bus.in1_valid = ($urandom_range(0, 3) != 0);
      bus.in0_data  = {gen_idx[0] == gen_len[0] - 1, gen_pay[0]};
      bus.in1_data  = {gen_idx[1] == gen_len[1] - 1, gen_pay[1]};
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? acc0 : acc1) begin
          gen_idx[p]++;
          gen_pay[p] = 8'($urandom);
          if (gen_idx[p] == gen_len[p]) begin
            gen_idx[p] = 0; gen_len[p] = $urandom_range(1, 4);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/merge2_leaf_arbiter.md
MERGE2_LEAF_ARBITER -- requirements
Module: merge2_leaf_arbiter

Interface
REQ-001 Parameter W, default 9, flit width in bits; bit W-1 is the tail marker (1 = last flit of packet).
REQ-002 CLK  input  1  single clock; all state on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 in0_data  input  W  requester 0 flit.
REQ-005 in0_valid  input  1  requester 0 flit present.
REQ-006 in0_ready  output  1  requester 0 flit accepted this cycle when valid&ready.
REQ-007 in1_data / in1_valid / in1_ready  W / 1 / 1  requester 1, same meaning as port 0.
REQ-008 out_data  output  W  registered merged flit.
REQ-009 out_valid  output  1  out_data holds a flit.
REQ-010 out_ready  input  1  downstream (decoder leaf) accepts when out_valid&out_ready.
REQ-011 out_src  output  1  registered index of the requester that supplied out_data.
REQ-012 busy  output  1  high while a multi-flit packet holds the grant.

Function
REQ-013 Single output register; slot_free = !out_valid | out_ready; a flit is accepted only when slot_free.
REQ-014 Latency: an accepted flit appears on out_data exactly 1 cycle later; full throughput (1 flit/cycle) under continuous out_ready.
REQ-015 FSM states IDLE, LOCK0, LOCK1; busy = (state != IDLE).
REQ-016 IDLE: if exactly one input valid, grant it; if both valid, grant the port named by round-robin pointer rr; if none, no grant.
REQ-017 IDLE: the granted port's ready = slot_free; the other port's ready = 0; all readies are 0 with no grant.
REQ-018 IDLE, accepted flit with tail=0 -> LOCKx (x = granted port); tail=1 -> stay IDLE (single-flit packet).
REQ-019 LOCKx: only port x ready (= slot_free); the other port is held off regardless of its valid.
REQ-020 LOCKx, accepted flit with tail=1 -> IDLE; stall (no valid or !slot_free) -> remain LOCKx, no timeout.
REQ-021 rr updates on every accepted header flit (first flit accepted in IDLE): rr <= ~granted port.
REQ-022 Flits within a packet are never interleaved with another port's flits.
REQ-023 out_data/out_src/out_valid hold stable while out_valid & !out_ready.
REQ-024 Simultaneous out_ready and new accept in the same cycle: the output register is reloaded, out_valid stays 1.

Reset
REQ-025 On RESET: state=IDLE, rr=0, out_valid=0, out_data=0, out_src=0, busy=0, in0_ready=in1_ready=0 while RESET high.
REQ-026 RESET asserted mid-packet drops the lock and any held flit; no partial-packet recovery; after release the next accepted flit is treated as a header.

Configuration
REQ-027 Macro MERGE2_PERF_CNT_EN: when defined, adds outputs pkt_cnt0, pkt_cnt1 (16 bits each) counting accepted tail flits per port, saturating at 16'hFFFF, cleared by RESET.
REQ-028 Without MERGE2_PERF_CNT_EN, the ports and counters are absent; all other behaviour is identical.

Structure
REQ-029 Shared package holds the FSM state enum, default flit width constant (9), and tail-bit index function/constant.
REQ-030 One sub-module rr_arb2 (2-way round-robin grant, combinational grant, registered pointer) is instantiated.

Verification
REQ-031 Both idle, in0 sends 1-flit packet 9'h1AA, out_ready=1 -> out_data=9'h1AA, out_src=0, out_valid one cycle later; state stays IDLE.
REQ-032 Both valid after reset (rr=0), each a 3-flit packet -> port 0's 3 flits emitted contiguously, then port 1's 3; busy high during each packet until its tail accepted.
REQ-033 Port 0 streams back-to-back 1-flit packets while port 1 holds valid -> strict alternation 0,1,0,1 on out_src.
REQ-034 out_ready=0 for 4 cycles with out_valid=1 -> out_data stable, both readies 0; on out_ready=1 the next flit appears the following cycle, no loss or duplicate.
REQ-035 RESET pulsed during LOCK1 after 2 of 4 flits -> out_valid=0, busy=0 immediately; next accepted flit from either port starts a new packet with rr=0.
REQ-036 With MERGE2_PERF_CNT_EN, 5 packets on port 1 -> pkt_cnt1=5, pkt_cnt0=0; counter forced to 16'hFFFF does not wrap on another tail.
